// File: rtl/regfile_sb_if.sv
// Writeback, read and issue signals for the integer register file with scoreboard.
// Reads and hazard/accept are combinational; writes and busy updates take effect on the clock edge.
interface regfile_sb_if #(
  parameter int REGBITS = 5,
  parameter int LOGSIZE = 64
);
  logic               wb_en;
  logic [REGBITS-1:0] wb_rd;
  logic [LOGSIZE-1:0] wb_data;
  logic [REGBITS-1:0] rs1_addr;
  logic [REGBITS-1:0] rs2_addr;
  logic [LOGSIZE-1:0] rs1_data;
  logic [LOGSIZE-1:0] rs2_data;
  logic               iss_valid;
  logic [REGBITS-1:0] iss_rd;
  logic               hazard;
  logic               iss_accept;

  modport master (
    output wb_en, wb_rd, wb_data, rs1_addr, rs2_addr, iss_valid, iss_rd,
    input  rs1_data, rs2_data, hazard, iss_accept
  );

  modport slave (
    input  wb_en, wb_rd, wb_data, rs1_addr, rs2_addr, iss_valid, iss_rd,
    output rs1_data, rs2_data, hazard, iss_accept
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with same-cycle writeback bypass and a per-register busy scoreboard.
// Zero-latency reads; issue is held via hazard until all source/dest producers have written back.
module regfile_sb #(
  parameter int REGBITS = 5,
  parameter int LOGSIZE = 64
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  rf
);
  localparam int NREGS = 2**REGBITS;

  logic [LOGSIZE-1:0] regs [NREGS];
  logic [NREGS-1:0]   busy;
  logic [NREGS-1:0]   wb_hit;
  logic [NREGS-1:0]   ebusy;
  logic [LOGSIZE-1:0] rd1;
  logic [LOGSIZE-1:0] rd2;
  logic               stall;
  logic               accept;

  always_comb begin
    wb_hit = '0;
    if (rf.wb_en) wb_hit[rf.wb_rd] = 1'b1;
    // A writeback landing this cycle retires its producer immediately.
    ebusy    = busy & ~wb_hit;
    ebusy[0] = 1'b0;
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!rst && rf.rs1_addr != '0)
      rd1 = (rf.wb_en && rf.wb_rd == rf.rs1_addr) ? rf.wb_data : regs[rf.rs1_addr];
    if (!rst && rf.rs2_addr != '0)
      rd2 = (rf.wb_en && rf.wb_rd == rf.rs2_addr) ? rf.wb_data : regs[rf.rs2_addr];
  end

  always_comb begin
    stall  = ebusy[rf.rs1_addr] | ebusy[rf.rs2_addr] | ebusy[rf.iss_rd];
    accept = !rst && rf.iss_valid && !stall;
  end

  assign rf.rs1_data   = rd1;
  assign rf.rs2_data   = rd2;
  assign rf.hazard     = !rst && rf.iss_valid && stall;
  assign rf.iss_accept = accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (rf.wb_en && rf.wb_rd != '0) begin
        regs[rf.wb_rd] <= rf.wb_data;
        busy[rf.wb_rd] <= 1'b0;
      end
      // Issued later so a same-register set overrides the writeback clear.
      if (accept && rf.iss_rd != '0)
        busy[rf.iss_rd] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized checks of regfile_sb against a reference register/busy model.
module tb_regfile_sb;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] mregs [32];
  bit   [31:0] mbusy;

  regfile_sb_if #(.REGBITS(5), .LOGSIZE(64)) rf ();

  regfile_sb #(.REGBITS(5), .LOGSIZE(64)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (rst || a == 5'd0) return 64'd0;
    if (rf.wb_en && rf.wb_rd == a) return rf.wb_data;
    return mregs[a];
  endfunction

  function automatic bit m_pending(input logic [4:0] r);
    return (r != 5'd0) && mbusy[r] && !(rf.wb_en && rf.wb_rd == r);
  endfunction

  function automatic bit m_blocked();
    return m_pending(rf.rs1_addr) || m_pending(rf.rs2_addr) || m_pending(rf.iss_rd);
  endfunction

  function automatic bit m_hazard();
    return !rst && rf.iss_valid && m_blocked();
  endfunction

  function automatic bit m_accept();
    return !rst && rf.iss_valid && !m_blocked();
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit we, input logic [4:0] wrd, input logic [63:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input bit iv, input logic [4:0] ir);
    rst         = r;
    rf.wb_en    = we;
    rf.wb_rd    = wrd;
    rf.wb_data  = wd;
    rf.rs1_addr = a1;
    rf.rs2_addr = a2;
    rf.iss_valid = iv;
    rf.iss_rd   = ir;
  endtask

  task automatic settle();
    @(negedge clk);
    check("rs1_data", rf.rs1_data, m_read(rf.rs1_addr));
    check("rs2_data", rf.rs2_data, m_read(rf.rs2_addr));
    check("hazard", {63'd0, rf.hazard}, {63'd0, m_hazard()});
    check("iss_accept", {63'd0, rf.iss_accept}, {63'd0, m_accept()});
  endtask

  task automatic tick(output bit accepted);
    bit acc;
    acc = m_accept();
    accepted = acc;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
      mbusy = '0;
    end else begin
      if (rf.wb_en && rf.wb_rd != 5'd0) begin
        mregs[rf.wb_rd] = rf.wb_data;
        mbusy[rf.wb_rd] = 1'b0;
      end
      if (acc && rf.iss_rd != 5'd0) mbusy[rf.iss_rd] = 1'b1;
    end
    #1;
  endtask

  initial begin
    bit          acc;
    bit          pv;
    logic [4:0]  prd, pa1, pa2, wrd;
    logic [63:0] wd;

    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    mbusy = '0;

    // Reset holds outputs low and ignores writeback/issue.
    drive(1, 1, 5'd1, 64'h5555, 5'd1, 5'd2, 1, 5'd3);
    settle();
    check("rst_hazard", {63'd0, rf.hazard}, 64'd0);
    check("rst_accept", {63'd0, rf.iss_accept}, 64'd0);
    tick(acc);
    drive(1, 0, 5'd0, 64'd0, 5'd1, 5'd1, 0, 5'd0);
    settle(); tick(acc);

    drive(0, 1, 5'd1, 64'hAAAA, 5'd0, 5'd0, 0, 5'd0); settle(); tick(acc);
    drive(0, 1, 5'd2, 64'hBBBB, 5'd0, 5'd0, 1, 5'd4); settle(); tick(acc);
    drive(0, 0, 5'd0, 64'd0, 5'd1, 5'd2, 0, 5'd0);
    settle();
    check("pre_rst_x1", rf.rs1_data, 64'hAAAA);
    check("pre_rst_x2", rf.rs2_data, 64'hBBBB);
    tick(acc);
    drive(1, 0, 5'd0, 64'd0, 5'd1, 5'd2, 0, 5'd0); settle(); tick(acc);
    drive(0, 0, 5'd0, 64'd0, 5'd1, 5'd2, 1, 5'd4);
    settle();
    check("post_rst_x1", rf.rs1_data, 64'd0);
    check("post_rst_x2", rf.rs2_data, 64'd0);
    check("post_rst_busy_cleared", {63'd0, rf.hazard}, 64'd0);
    tick(acc);
    drive(0, 1, 5'd4, 64'h4444, 5'd0, 5'd0, 0, 5'd0); settle(); tick(acc);

    // x0 is hardwired to zero and never stalls.
    drive(0, 1, 5'd0, 64'hDEAD, 5'd0, 5'd0, 0, 5'd0);
    settle();
    check("x0_bypass", rf.rs1_data, 64'd0);
    tick(acc);
    drive(0, 0, 5'd0, 64'd0, 5'd0, 5'd0, 1, 5'd0);
    settle();
    check("x0_read", rf.rs1_data, 64'd0);
    check("x0_accept", {63'd0, rf.iss_accept}, 64'd1);
    tick(acc);
    drive(0, 0, 5'd0, 64'd0, 5'd0, 5'd0, 1, 5'd0);
    settle();
    check("x0_nostall", {63'd0, rf.hazard}, 64'd0);
    tick(acc);

    // Same-cycle bypass, then storage read.
    drive(0, 1, 5'd5, 64'h1234, 5'd5, 5'd0, 0, 5'd0);
    settle();
    check("bypass_same", rf.rs1_data, 64'h1234);
    tick(acc);
    drive(0, 0, 5'd0, 64'd0, 5'd5, 5'd0, 0, 5'd0);
    settle();
    check("bypass_stored", rf.rs1_data, 64'h1234);
    tick(acc);

    // RAW stall held for 3 cycles, released by the writeback itself.
    drive(0, 0, 5'd0, 64'd0, 5'd0, 5'd0, 1, 5'd7);
    settle();
    check("raw_issue", {63'd0, rf.iss_accept}, 64'd1);
    tick(acc);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 5'd0, 64'd0, 5'd0, 5'd7, 1, 5'd8);
      settle();
      check("raw_hazard", {63'd0, rf.hazard}, 64'd1);
      check("raw_hold", {63'd0, rf.iss_accept}, 64'd0);
      tick(acc);
    end
    drive(0, 1, 5'd7, 64'hCAFE_F00D, 5'd0, 5'd7, 1, 5'd8);
    settle();
    check("raw_release", {63'd0, rf.hazard}, 64'd0);
    check("raw_data", rf.rs2_data, 64'hCAFE_F00D);
    tick(acc);

    // WAW collision: new producer accepted as the old one writes back; set wins.
    drive(0, 0, 5'd0, 64'd0, 5'd0, 5'd0, 1, 5'd9); settle(); tick(acc);
    drive(0, 1, 5'd9, 64'h9999, 5'd0, 5'd0, 1, 5'd9);
    settle();
    check("waw_accept", {63'd0, rf.iss_accept}, 64'd1);
    tick(acc);
    drive(0, 0, 5'd0, 64'd0, 5'd9, 5'd0, 1, 5'd9);
    settle();
    check("waw_data", rf.rs1_data, 64'h9999);
    check("waw_still_busy", {63'd0, rf.hazard}, 64'd1);
    tick(acc);

    // Random issue/writeback traffic; an instruction is re-presented until accepted.
    pv = 0; prd = 0; pa1 = 0; pa2 = 0;
    for (int n = 0; n < 10000; n++) begin
      if (!pv || acc) begin
        pv  = ($urandom_range(0, 3) != 0);
        prd = 5'($urandom_range(0, 15));
        pa1 = 5'($urandom_range(0, 15));
        pa2 = 5'($urandom_range(0, 31));
      end
      wrd = 5'($urandom_range(0, 15));
      for (int k = 0; k < 4 && !mbusy[wrd]; k++) wrd = 5'($urandom_range(0, 15));
      wd = {$urandom, $urandom};
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0, wrd, wd, pa1, pa2, pv, prd);
      settle();
      tick(acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
